// File: rtl/fifo_deserializer_if.sv
// Handshake bundle for fifo_deserializer: FWFT FIFO pop side plus the
// downstream valid/yumi vector side.
interface fifo_deserializer_if #(
   parameter int LAYER_HEIGHT = 64,
   parameter int WORD_SIZE    = 16
);
   logic [WORD_SIZE-1:0]                   data_i;
   logic                                   empty_i;
   logic                                   ren_o;
   logic [LAYER_HEIGHT-1:0][WORD_SIZE-1:0] data_o;
   logic                                   valid_o;
   logic                                   yumi_i;

   // master is the deserializer itself; slave is the surrounding FIFO/consumer
   modport master (
      input  data_i, empty_i, yumi_i,
      output ren_o, data_o, valid_o
   );

   modport slave (
      output data_i, empty_i, yumi_i,
      input  ren_o, data_o, valid_o
   );
endinterface

// File: rtl/fifo_deserializer.sv
// Pops LAYER_HEIGHT words from a first-word-fall-through FIFO and presents them
// as one packed vector on a valid/yumi handshake; word k lands in slot k.
module fifo_deserializer #(
   parameter int LAYER_HEIGHT = 64,
   parameter int WORD_SIZE    = 16
) (
   input  logic                clk_i,
   input  logic                reset_i,
   fifo_deserializer_if.master bus
);
   localparam int              CW   = (LAYER_HEIGHT > 1) ? $clog2(LAYER_HEIGHT) : 1;
   localparam logic [CW-1:0]   LAST = CW'(LAYER_HEIGHT - 1);
   localparam logic [0:0]      FILL = 1'b0;
   localparam logic [0:0]      HOLD = 1'b1;

   logic [0:0]                             state_reg, state_next;
   logic [CW-1:0]                          count_reg, count_next;
   logic [LAYER_HEIGHT-1:0][WORD_SIZE-1:0] data_reg;
   logic                                   pop;

   // Gating with reset keeps the FIFO untouched while the block is being cleared.
   assign pop = (state_reg == FILL) && !bus.empty_i && !reset_i;

   always_comb begin
      state_next = state_reg;
      count_next = count_reg;
      case (state_reg)
         FILL: begin
            if (pop) begin
               if (count_reg == LAST) begin
                  count_next = '0;
                  state_next = HOLD;
               end else begin
                  count_next = count_reg + CW'(1);
               end
            end
         end
         HOLD: begin
            if (bus.yumi_i) begin
               state_next = FILL;
            end
         end
         default: state_next = FILL;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_reg <= FILL;
         count_reg <= '0;
      end else begin
         state_reg <= state_next;
         count_reg <= count_next;
      end
   end

   // One write-enabled register per slot; only the slot under count captures.
   generate
      for (genvar gi = 0; gi < LAYER_HEIGHT; gi++) begin : g_slot
         always_ff @(posedge clk_i) begin
            if (reset_i) begin
               data_reg[gi] <= '0;
            end else if (pop && (count_reg == CW'(gi))) begin
               data_reg[gi] <= bus.data_i;
            end
         end
      end
   endgenerate

   assign bus.ren_o   = pop;
   assign bus.data_o  = data_reg;
   assign bus.valid_o = (state_reg == HOLD);

endmodule

// File: tb/tb_fifo_deserializer.sv
// Directed bench for fifo_deserializer: a queue models the FWFT FIFO and each
// scenario task checks its own expectations inline.
module tb_fifo_deserializer;
   localparam int LH = 64;
   localparam int WS = 16;

   logic clk;
   logic reset_i;

   fifo_deserializer_if #(.LAYER_HEIGHT(LH), .WORD_SIZE(WS)) bus ();

   fifo_deserializer #(.LAYER_HEIGHT(LH), .WORD_SIZE(WS)) dut (
      .clk_i   (clk),
      .reset_i (reset_i),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [WS-1:0] q[$];
   bit            starve;
   bit            tie_yumi;
   bit            yumi_drv;
   int            ren_violations;
   int            pass_cnt;
   int            total_cnt;

   // One clock cycle, entered and left at a falling edge; reports whether a pop happened.
   task automatic cycle(output bit popped);
      bus.yumi_i  = tie_yumi ? bus.valid_o : yumi_drv;
      bus.empty_i = (q.size() == 0) || starve;
      bus.data_i  = (q.size() != 0) ? q[0] : '0;
      #1;
      popped = bus.ren_o;
      if (popped && bus.empty_i) ren_violations++;
      @(posedge clk);
      if (popped && q.size() != 0) void'(q.pop_front());
      @(negedge clk);
   endtask

   task automatic do_reset();
      bit p;
      q.delete();
      starve   = 0;
      tie_yumi = 0;
      yumi_drv = 0;
      reset_i  = 1;
      cycle(p);
      reset_i  = 0;
   endtask

   task automatic test_reset();
      bit p;
      q.delete();
      q.push_back(16'h5555);
      reset_i = 1;
      cycle(p);
      total_cnt++;
      if (p !== 1'b0) $display("FAIL reset_ren got %0b exp 0", p); else pass_cnt++;
      total_cnt++;
      if (bus.valid_o !== 1'b0) $display("FAIL reset_valid got %0b exp 0", bus.valid_o); else pass_cnt++;
      total_cnt++;
      if (bus.data_o !== '0) $display("FAIL reset_data got nonzero exp 0"); else pass_cnt++;
      reset_i = 0;
      $display("test_reset done");
   endtask

   // Basic fill, then 20 idle cycles, then 50 cycles of backpressure and a one-cycle yumi.
   task automatic test_basic_fill_and_backpressure();
      bit p;
      int pops;
      int hold_pops;
      int bad_valid;
      int bad_idx;
      logic [LH-1:0][WS-1:0] exp_v;
      do_reset();
      for (int k = 0; k < LH; k++) begin
         q.push_back(WS'(k));
         exp_v[k] = WS'(k);
      end
      pops = 0;
      for (int i = 0; i < 200; i++) begin
         cycle(p);
         if (p) pops++;
         if (bus.valid_o) break;
      end
      total_cnt++;
      if (pops != LH) $display("FAIL basic_pops got %0d exp %0d", pops, LH); else pass_cnt++;
      total_cnt++;
      if (bus.valid_o !== 1'b1) $display("FAIL basic_valid got %0b exp 1", bus.valid_o); else pass_cnt++;
      bad_idx = -1;
      for (int k = LH - 1; k >= 0; k--) if (bus.data_o[k] !== exp_v[k]) bad_idx = k;
      total_cnt++;
      if (bad_idx >= 0) $display("FAIL basic_data slot %0d got %h exp %h", bad_idx, bus.data_o[bad_idx], exp_v[bad_idx]);
      else pass_cnt++;
      for (int k = 0; k < 8; k++) q.push_back(WS'(16'h2000 + k));
      hold_pops = 0;
      bad_valid = 0;
      for (int i = 0; i < 20; i++) begin
         cycle(p);
         if (p) hold_pops++;
         if (bus.valid_o !== 1'b1) bad_valid++;
      end
      total_cnt++;
      if (hold_pops != 0) $display("FAIL hold_pops got %0d exp 0", hold_pops); else pass_cnt++;
      total_cnt++;
      if (bad_valid != 0) $display("FAIL hold_valid got %0d drops exp 0", bad_valid); else pass_cnt++;
      hold_pops = 0;
      bad_valid = 0;
      bad_idx   = 0;
      for (int i = 0; i < 50; i++) begin
         cycle(p);
         if (p) hold_pops++;
         if (bus.valid_o !== 1'b1) bad_valid++;
         if (bus.data_o !== exp_v) bad_idx++;
      end
      total_cnt++;
      if (hold_pops != 0) $display("FAIL bp_pops got %0d exp 0", hold_pops); else pass_cnt++;
      total_cnt++;
      if (bad_valid != 0) $display("FAIL bp_valid got %0d drops exp 0", bad_valid); else pass_cnt++;
      total_cnt++;
      if (bad_idx != 0) $display("FAIL bp_data got %0d changed cycles exp 0", bad_idx); else pass_cnt++;
      yumi_drv = 1;
      cycle(p);
      yumi_drv = 0;
      total_cnt++;
      if (p !== 1'b0) $display("FAIL yumi_cycle_ren got %0b exp 0", p); else pass_cnt++;
      total_cnt++;
      if (bus.valid_o !== 1'b0) $display("FAIL yumi_valid_drop got %0b exp 0", bus.valid_o); else pass_cnt++;
      cycle(p);
      total_cnt++;
      if (p !== 1'b1) $display("FAIL resume_pop got %0b exp 1", p); else pass_cnt++;
      $display("test_basic_fill_and_backpressure done: pops=%0d", pops);
   endtask

   task automatic test_starved();
      bit p;
      int pops;
      int last_pop;
      int rise;
      int bad_idx;
      do_reset();
      ren_violations = 0;
      for (int k = 0; k < LH; k++) q.push_back(WS'(k));
      pops     = 0;
      last_pop = -1;
      rise     = -1;
      for (int i = 0; i < 400; i++) begin
         starve = (i % 3) != 0;
         cycle(p);
         if (p) begin
            pops++;
            if (pops == LH) last_pop = i;
         end
         if (bus.valid_o && rise < 0) begin
            rise = i;
            break;
         end
      end
      starve = 0;
      total_cnt++;
      if (ren_violations != 0) $display("FAIL starved_ren_on_empty got %0d exp 0", ren_violations); else pass_cnt++;
      total_cnt++;
      if (rise != last_pop || rise < 0) $display("FAIL starved_valid_timing got rise %0d exp %0d", rise, last_pop);
      else pass_cnt++;
      bad_idx = -1;
      for (int k = LH - 1; k >= 0; k--) if (bus.data_o[k] !== WS'(k)) bad_idx = k;
      total_cnt++;
      if (bad_idx >= 0) $display("FAIL starved_data slot %0d got %h exp %h", bad_idx, bus.data_o[bad_idx], WS'(bad_idx));
      else pass_cnt++;
      $display("test_starved done: last pop cycle %0d, valid cycle %0d", last_pop, rise);
   endtask

   task automatic test_back_to_back();
      bit p;
      bit prev_valid;
      int rises;
      int rise_at[2];
      int bad1;
      int bad2;
      do_reset();
      for (int k = 0; k < 2 * LH; k++) q.push_back(WS'(16'h1000 + k));
      tie_yumi   = 1;
      prev_valid = 0;
      rises      = 0;
      bad1       = -1;
      bad2       = -1;
      for (int i = 0; i < 400; i++) begin
         cycle(p);
         if (bus.valid_o && !prev_valid) begin
            if (rises < 2) rise_at[rises] = i;
            for (int k = LH - 1; k >= 0; k--) begin
               if (rises == 0 && bus.data_o[k] !== WS'(16'h1000 + k)) bad1 = k;
               if (rises == 1 && bus.data_o[k] !== WS'(16'h1040 + k)) bad2 = k;
            end
            rises++;
         end
         prev_valid = bus.valid_o;
         if (rises == 2 && !bus.valid_o) break;
      end
      tie_yumi = 0;
      total_cnt++;
      if (rises != 2) $display("FAIL b2b_vectors got %0d exp 2", rises); else pass_cnt++;
      total_cnt++;
      if (rises < 2 || (rise_at[1] - rise_at[0]) != LH + 1)
         $display("FAIL b2b_spacing got %0d exp %0d", (rises < 2) ? -1 : rise_at[1] - rise_at[0], LH + 1);
      else pass_cnt++;
      total_cnt++;
      if (bad1 >= 0) $display("FAIL b2b_data1 slot %0d got bad exp %h", bad1, WS'(16'h1000 + bad1)); else pass_cnt++;
      total_cnt++;
      if (bad2 >= 0) $display("FAIL b2b_data2 slot %0d got bad exp %h", bad2, WS'(16'h1040 + bad2)); else pass_cnt++;
      $display("test_back_to_back done: vectors=%0d", rises);
   endtask

   task automatic test_reset_mid_fill();
      bit p;
      int pops;
      int bad_idx;
      do_reset();
      for (int k = 0; k < 10; k++) q.push_back(16'hAAAA);
      for (int i = 0; i < 10; i++) cycle(p);
      reset_i = 1;
      cycle(p);
      reset_i = 0;
      total_cnt++;
      if (bus.data_o !== '0) $display("FAIL midreset_data got %h in slot 0 exp 0", bus.data_o[0]); else pass_cnt++;
      total_cnt++;
      if (bus.valid_o !== 1'b0) $display("FAIL midreset_valid got %0b exp 0", bus.valid_o); else pass_cnt++;
      for (int k = 0; k < LH; k++) q.push_back(WS'(16'h3000 + k));
      pops = 0;
      for (int i = 0; i < 200; i++) begin
         cycle(p);
         if (p) pops++;
         if (bus.valid_o) break;
      end
      total_cnt++;
      if (pops != LH || bus.valid_o !== 1'b1) $display("FAIL midreset_refill got %0d pops valid %0b exp %0d pops valid 1", pops, bus.valid_o, LH);
      else pass_cnt++;
      bad_idx = -1;
      for (int k = LH - 1; k >= 0; k--) if (bus.data_o[k] !== WS'(16'h3000 + k)) bad_idx = k;
      total_cnt++;
      if (bad_idx >= 0) $display("FAIL midreset_order slot %0d got %h exp %h", bad_idx, bus.data_o[bad_idx], WS'(16'h3000 + bad_idx));
      else pass_cnt++;
      $display("test_reset_mid_fill done: pops=%0d", pops);
   endtask

   task automatic test_stray_yumi();
      bit p;
      int pops;
      int early_valid;
      int bad_idx;
      do_reset();
      for (int k = 0; k < LH; k++) q.push_back(WS'(16'h4000 + k));
      for (int k = 0; k < 4; k++) q.push_back(WS'(16'h5000 + k));
      pops        = 0;
      early_valid = 0;
      for (int i = 0; i < 200; i++) begin
         // yumi pulses at count 5 and again alongside the final pop
         yumi_drv = (pops == 5) || (pops == LH - 1);
         cycle(p);
         if (p) pops++;
         if (bus.valid_o && pops < LH) early_valid++;
         if (bus.valid_o) break;
      end
      yumi_drv = 0;
      total_cnt++;
      if (early_valid != 0) $display("FAIL stray_early_valid got %0d exp 0", early_valid); else pass_cnt++;
      total_cnt++;
      if (pops != LH) $display("FAIL stray_pops got %0d exp %0d", pops, LH); else pass_cnt++;
      bad_idx = -1;
      for (int k = LH - 1; k >= 0; k--) if (bus.data_o[k] !== WS'(16'h4000 + k)) bad_idx = k;
      total_cnt++;
      if (bad_idx >= 0) $display("FAIL stray_data slot %0d got %h exp %h", bad_idx, bus.data_o[bad_idx], WS'(16'h4000 + bad_idx));
      else pass_cnt++;
      cycle(p);
      total_cnt++;
      if (bus.valid_o !== 1'b1 || p !== 1'b0) $display("FAIL stray_last_yumi valid %0b ren %0b exp valid 1 ren 0", bus.valid_o, p);
      else pass_cnt++;
      $display("test_stray_yumi done: pops=%0d", pops);
   endtask

   initial begin
      pass_cnt       = 0;
      total_cnt      = 0;
      ren_violations = 0;
      starve         = 0;
      tie_yumi       = 0;
      yumi_drv       = 0;
      reset_i        = 1;
      bus.data_i     = '0;
      bus.empty_i    = 1'b1;
      bus.yumi_i     = 1'b0;
      @(negedge clk);
      test_reset();
      test_basic_fill_and_backpressure();
      test_starved();
      test_back_to_back();
      test_reset_mid_fill();
      test_stray_yumi();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
